mem_arbiter: RTL and testbench

- Shares the single-port 4096x8 main memory between the CPU data/fetch port and a debug/loader port.
- Serialises 16-bit little-endian word accesses into two byte cycles on the 8-bit memory.
- Arbitrates between the two requesters round-robin and returns a one-cycle acknowledge with read data.
- Sits between the CPU core, the image loader and the synchronous-read memory array.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous-read memory between the CPU and
// debug/loader ports; 16-bit accesses are split into two little-endian byte cycles.
module mem_arbiter #(
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic          clock,
  input  logic          reset_n,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_word,
  input  logic [15:0]   cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic [15:0]   cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_word,
  input  logic [15:0]   dbg_addr,
  input  logic [15:0]   dbg_wdata,
  output logic          dbg_ack,
  output logic [15:0]   dbg_rdata,

  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [2:0] {IDLE, LO, HI, LAST, DONE} state_t;

  state_t        state, state_next;

  logic          grant_any;
  logic          grant_dbg;
  logic          sel_we;
  logic          sel_word;
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_wdata;

  logic          own_dbg;
  logic          last_dbg;
  logic          lat_we;
  logic          lat_word;
  logic [AW-1:0] lat_addr;
  logic [15:0]   lat_wdata;
  logic [7:0]    rdata_lo;
  logic [15:0]   rdata_next;

  logic [AW:0]   addr_inc;
  logic [AW-1:0] addr_hi;
  logic          unused_addr;

  // Upper requester address bits are deliberately ignored.
  assign unused_addr = ^{cpu_addr, dbg_addr};

  // When both ports request, the one that did not own the previous access wins.
  always_comb begin
    grant_any = cpu_req | dbg_req;
    grant_dbg = 1'b0;
    if (cpu_req && dbg_req) begin
      grant_dbg = ~last_dbg;
    end else if (dbg_req) begin
      grant_dbg = 1'b1;
    end
  end

  assign sel_we    = grant_dbg ? dbg_we    : cpu_we;
  assign sel_word  = grant_dbg ? dbg_word  : cpu_word;
  assign sel_addr  = grant_dbg ? dbg_addr[AW-1:0] : cpu_addr[AW-1:0];
  assign sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;

  assign addr_inc = {1'b0, lat_addr} + 1'b1;
  assign addr_hi  = (addr_inc == (AW+1)'(DEPTH)) ? '0 : addr_inc[AW-1:0];

  assign rdata_next = lat_word ? {mem_rdata, rdata_lo} : {8'h00, mem_rdata};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory strobes are decoded from the state so an async reset removes them at once.
  always_comb begin
    state_next = state;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          state_next = LO;
        end
      end
      LO: begin
        mem_addr   = lat_addr;
        mem_we     = lat_we;
        mem_wdata  = lat_wdata[7:0];
        state_next = lat_word ? HI : LAST;
      end
      HI: begin
        mem_addr   = addr_hi;
        mem_we     = lat_we;
        mem_wdata  = lat_wdata[15:8];
        state_next = LAST;
      end
      LAST: begin
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      own_dbg   <= 1'b0;
      last_dbg  <= 1'b1;
      lat_we    <= 1'b0;
      lat_word  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_lo  <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            own_dbg   <= grant_dbg;
            lat_we    <= sel_we;
            lat_word  <= sel_word;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
          end
        end
        HI: begin
          rdata_lo <= mem_rdata;
        end
        LAST: begin
          if (own_dbg) begin
            dbg_rdata <= rdata_next;
            dbg_ack   <= 1'b1;
          end else begin
            cpu_rdata <= rdata_next;
            cpu_ack   <= 1'b1;
          end
        end
        DONE: begin
          last_dbg <= own_dbg;
        end
        default: begin
        end
      endcase
    end
  end

  // Structural invariants of the handshake and memory strobe.
  assert property (@(posedge clock) disable iff (!reset_n)
                   mem_we |-> (state == LO || state == HI));
  assert property (@(posedge clock) disable iff (!reset_n)
                   !(cpu_ack && dbg_ack));
  assert property (@(posedge clock) disable iff (!reset_n)
                   (cpu_ack || dbg_ack) |-> (state == DONE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-wide memory model, per-port scoreboards fed by a
// high-level memory image model, and a negedge monitor comparing every ack.
module tb_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_word;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_word;
  logic [15:0] dbg_addr, dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem_array [4096] = '{default: 8'h00};
  logic [7:0]  ref_mem   [4096] = '{default: 8'h00};
  logic        load_en;
  logic [11:0] load_addr;
  logic [7:0]  load_data;

  typedef struct {
    bit          chk;
    logic [15:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dbg_q[$];
  int   ack_port[$];
  int   ack_cyc[$];

  int checks;
  int failures;
  int cyc;

  mem_arbiter #(.AW(12), .DEPTH(4096)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_word  (cpu_word),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_word  (dbg_word),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read byte memory, read-before-write, with a bench-side preload path.
  always @(posedge clock) begin
    if (load_en) begin
      mem_array[load_addr] <= load_data;
    end else if (mem_we) begin
      mem_array[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_array[mem_addr];
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] addr, input bit word);
    int a0 = int'(addr) % 4096;
    int a1 = (a0 + 1) % 4096;
    return word ? {ref_mem[a1], ref_mem[a0]} : {8'h00, ref_mem[a0]};
  endfunction

  function automatic void model_write(input logic [15:0] addr, input bit word, input logic [15:0] wdata);
    int a0 = int'(addr) % 4096;
    int a1 = (a0 + 1) % 4096;
    ref_mem[a0] = wdata[7:0];
    if (word) ref_mem[a1] = wdata[15:8];
  endfunction

  // One complete requester access: queue the expectation, hold req until ack, drop it
  // during the ack cycle and return in the following IDLE cycle.
  task automatic apply_stimulus(input bit port, input bit we, input bit word,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                output int lat);
    exp_t e;
    int   start;
    bit   seen;
    e.chk  = !we;
    e.data = model_read(addr, word);
    if (we) model_write(addr, word, wdata);
    if (port) begin
      dbg_q.push_back(e);
      dbg_we = we; dbg_word = word; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_q.push_back(e);
      cpu_we = we; cpu_word = word; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    start = cyc;
    seen  = 1'b0;
    lat   = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clock); #1;
      if (port ? dbg_ack : cpu_ack) begin
        seen = 1'b1;
        lat  = cyc - start;
      end
    end
    if (port) dbg_req = 1'b0; else cpu_req = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout port=%0d actual=no_ack required=ack", port);
    end
    @(posedge clock); #1;
  endtask

  // Monitor: every ack pops that port's scoreboard; reads compare rdata.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (cpu_ack || dbg_ack) begin
        check_output("ack_exclusive", 16'(cpu_ack & dbg_ack), 16'd0);
      end
      if (cpu_ack) begin
        ack_port.push_back(0);
        ack_cyc.push_back(cyc);
        if (cpu_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL cpu_unexpected_ack actual=ack required=none");
        end else begin
          e = cpu_q.pop_front();
          if (e.chk) check_output("cpu_rdata", cpu_rdata, e.data);
        end
      end
      if (dbg_ack) begin
        ack_port.push_back(1);
        ack_cyc.push_back(cyc);
        if (dbg_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL dbg_unexpected_ack actual=ack required=none");
        end else begin
          e = dbg_q.pop_front();
          if (e.chk) check_output("dbg_rdata", dbg_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat_a, lat_b, n_cpu, n_dbg, diffs;
    exp_t e;
    checks = 0; failures = 0;
    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_word = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_word = 0; dbg_addr = 0; dbg_wdata = 0;
    load_en = 0; load_addr = 0; load_data = 0;

    // Preload random contents while the arbiter is held in reset.
    @(posedge clock); #1;
    for (int i = 0; i < 200; i++) begin
      load_addr = 12'($urandom_range(0, 4095));
      load_data = 8'($urandom);
      ref_mem[load_addr] = load_data;
      load_en = 1'b1;
      @(posedge clock); #1;
    end
    load_addr = 12'h010; load_data = 8'hA5; ref_mem[12'h010] = 8'hA5;
    @(posedge clock); #1;
    load_en = 1'b0;

    check_output("reset_cpu_ack",   16'(cpu_ack),   16'd0);
    check_output("reset_dbg_ack",   16'(dbg_ack),   16'd0);
    check_output("reset_cpu_rdata", cpu_rdata,      16'd0);
    check_output("reset_dbg_rdata", dbg_rdata,      16'd0);
    check_output("reset_mem_we",    16'(mem_we),    16'd0);
    check_output("reset_mem_addr",  16'(mem_addr),  16'd0);
    check_output("reset_mem_wdata", 16'(mem_wdata), 16'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // CPU byte read.
    apply_stimulus(0, 0, 0, 16'h0010, 16'h0000, lat_a);
    check_output("cpu_byte_read_latency", 16'(lat_a), 16'd3);
    check_output("cpu_byte_read_data", cpu_rdata, 16'h00A5);

    // Debug word write then CPU word read of the same location.
    apply_stimulus(1, 1, 1, 16'h0100, 16'hBEEF, lat_a);
    check_output("dbg_word_write_latency", 16'(lat_a), 16'd4);
    check_output("mem_100", 16'(mem_array[12'h100]), 16'h00EF);
    check_output("mem_101", 16'(mem_array[12'h101]), 16'h00BE);
    apply_stimulus(0, 0, 1, 16'h0100, 16'h0000, lat_a);
    check_output("cpu_word_read_latency", 16'(lat_a), 16'd4);
    check_output("cpu_word_read_data", cpu_rdata, 16'hBEEF);

    // Word write straddling the top of memory, then read back through an aliased address.
    apply_stimulus(0, 1, 1, 16'h0FFF, 16'h1234, lat_a);
    check_output("mem_fff", 16'(mem_array[12'hFFF]), 16'h0034);
    check_output("mem_000", 16'(mem_array[12'h000]), 16'h0012);
    apply_stimulus(0, 0, 1, 16'hFFFF, 16'h0000, lat_a);
    check_output("wrap_read_data", cpu_rdata, 16'h1234);

    // Both ports requesting continuously straight out of reset.
    reset_n = 1'b0;
    @(posedge clock); @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    ack_port.delete(); ack_cyc.delete();
    for (int i = 0; i < 2; i++) begin
      e.chk = 1'b1; e.data = model_read(16'h0010, 0); cpu_q.push_back(e);
      e.data = model_read(16'h0020, 0); dbg_q.push_back(e);
    end
    cpu_we = 0; cpu_word = 0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    dbg_we = 0; dbg_word = 0; dbg_addr = 16'h0020; dbg_req = 1'b1;
    n_cpu = 0; n_dbg = 0;
    for (int i = 0; i < 60 && (n_cpu < 2 || n_dbg < 2); i++) begin
      @(posedge clock); #1;
      if (cpu_ack) begin n_cpu++; if (n_cpu == 2) cpu_req = 1'b0; end
      if (dbg_ack) begin n_dbg++; if (n_dbg == 2) dbg_req = 1'b0; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(posedge clock); #1;
    check_output("rr_ack_count", 16'(ack_port.size()), 16'd4);
    for (int i = 0; i < 4 && i < ack_port.size(); i++) begin
      check_output($sformatf("rr_grant_%0d", i), 16'(ack_port[i]), 16'(i % 2));
      if (i > 0) check_output($sformatf("rr_gap_%0d", i), 16'(ack_cyc[i] - ack_cyc[i-1]), 16'd4);
    end

    // Reset pulsed during the high-byte cycle of a word write.
    cpu_we = 1; cpu_word = 1; cpu_addr = 16'h0200; cpu_wdata = 16'hCAFE; cpu_req = 1'b1;
    @(posedge clock); #1;
    check_output("lo_mem_we",    16'(mem_we),    16'd1);
    check_output("lo_mem_addr",  16'(mem_addr),  16'h0200);
    check_output("lo_mem_wdata", 16'(mem_wdata), 16'h00FE);
    @(posedge clock); #1;
    check_output("hi_mem_addr",  16'(mem_addr),  16'h0201);
    check_output("hi_mem_wdata", 16'(mem_wdata), 16'h00CA);
    reset_n = 1'b0;
    #1;
    check_output("abort_mem_we", 16'(mem_we), 16'd0);
    cpu_req = 1'b0;
    @(posedge clock); @(negedge clock);
    check_output("abort_cpu_ack", 16'(cpu_ack), 16'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_output("abort_mem_200", 16'(mem_array[12'h200]), 16'h00FE);
    check_output("abort_mem_201", 16'(mem_array[12'h201]), 16'(ref_mem[12'h201]));
    ref_mem[12'h200] = 8'hFE;
    apply_stimulus(0, 0, 0, 16'h0200, 16'h0000, lat_a);
    check_output("post_abort_latency", 16'(lat_a), 16'd3);
    check_output("post_abort_data", cpu_rdata, 16'h00FE);

    // Debug request arriving while the CPU byte write is in flight.
    fork
      apply_stimulus(0, 1, 0, 16'h0300, 16'h005A, lat_a);
      begin
        @(posedge clock); #1;
        apply_stimulus(1, 0, 0, 16'h0300, 16'h0000, lat_b);
      end
    join
    check_output("late_cpu_latency", 16'(lat_a), 16'd3);
    check_output("late_dbg_latency", 16'(lat_b), 16'd6);
    check_output("late_dbg_data", dbg_rdata, 16'h005A);

    // Random traffic on both ports in disjoint regions.
    fork
      begin : cpu_rand
        int lat_c;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          apply_stimulus(0, 1'($urandom), 1'($urandom),
                         {4'($urandom), 12'($urandom_range(12'h000, 12'h7FE))},
                         16'($urandom), lat_c);
        end
      end
      begin : dbg_rand
        int lat_d;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          apply_stimulus(1, 1'($urandom), 1'($urandom),
                         {4'($urandom), 12'($urandom_range(12'h800, 12'hFFE))},
                         16'($urandom), lat_d);
        end
      end
    join
    repeat (4) @(posedge clock);
    #1;
    diffs = 0;
    for (int i = 0; i < 4096; i++) begin
      if (mem_array[i] !== ref_mem[i]) diffs++;
    end
    check_output("mem_image_mismatches", 16'(diffs), 16'd0);
    check_output("cpu_queue_left", 16'(cpu_q.size()), 16'd0);
    check_output("dbg_queue_left", 16'(dbg_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
